// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// ID word and default window base.
package dmem_pkg;

    localparam int unsigned   DMEM_ADDR_W    = 12;
    localparam int unsigned   DMEM_DATA_W    = 32;
    localparam logic [11:0]   DMEM_MMIO_BASE = 12'hFF0;

    localparam logic [3:0]    OFF_LED   = 4'd0;
    localparam logic [3:0]    OFF_CYCLE = 4'd1;
    localparam logic [3:0]    OFF_WRCNT = 4'd2;
    localparam logic [3:0]    OFF_ID    = 4'd3;

    localparam logic [31:0]   ID_VALUE  = 32'h0550_D3E0;

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port synchronous RAM with old-data read-during-write and no reset,
// written so synthesis maps it onto block RAM.
module dmem_ram_1rw #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    // Write and read on the same edge; the read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: syncram-compatible RAM below MMIO_BASE and a
// 16-word MMIO window (LED, cycle counter, RAM write counter, ID) above it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned       DATA_W    = DMEM_DATA_W,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DMEM_MMIO_BASE),
    parameter int unsigned       LED_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic [LED_W-1:0]  led_out,
    output logic              mmio_hit
);

    logic              is_mmio_s;
    logic [3:0]        mmio_off_s;
    logic              ram_we_s;
    logic              mmio_we_s;
    logic [DATA_W-1:0] ram_q_s;

    logic [LED_W-1:0]  led_nxt_s;
    logic [31:0]       cycle_nxt_s;
    logic [31:0]       wr_cnt_nxt_s;
    logic [DATA_W-1:0] mmio_rd_s;

    logic [LED_W-1:0]  led_r;
    logic [31:0]       cycle_cnt_r;
    logic [31:0]       wr_cnt_r;
    logic [DATA_W-1:0] mmio_q_r;
    logic              mmio_hit_r;
    logic              ram_sel_r;

    assign is_mmio_s  = (address >= MMIO_BASE);
    assign mmio_off_s = 4'(address - MMIO_BASE);
    // Writes sampled while reset is held must not reach the unreset RAM.
    assign ram_we_s   = wren & reset & ~is_mmio_s;
    assign mmio_we_s  = wren & is_mmio_s;

    dmem_ram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (address),
        .wdata (data),
        .rdata (ram_q_s)
    );

    // Next-state of the MMIO registers and read mux of their pre-edge values.
    always_comb begin
        led_nxt_s    = led_r;
        cycle_nxt_s  = cycle_cnt_r + 32'd1;
        wr_cnt_nxt_s = wr_cnt_r;
        mmio_rd_s    = {DATA_W{1'b0}};

        if (mmio_we_s && (mmio_off_s == OFF_LED)) begin
            led_nxt_s = data[LED_W-1:0];
        end else begin
            led_nxt_s = led_r;
        end

        if (mmio_we_s && (mmio_off_s == OFF_CYCLE)) begin
            cycle_nxt_s = 32'(data);
        end else begin
            cycle_nxt_s = cycle_cnt_r + 32'd1;
        end

        if (mmio_we_s && (mmio_off_s == OFF_WRCNT)) begin
            wr_cnt_nxt_s = 32'd0;
        end else if (ram_we_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
            wr_cnt_nxt_s = wr_cnt_r + 32'd1;
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        case (mmio_off_s)
            OFF_LED:   mmio_rd_s = DATA_W'(led_r);
            OFF_CYCLE: mmio_rd_s = DATA_W'(cycle_cnt_r);
            OFF_WRCNT: mmio_rd_s = DATA_W'(wr_cnt_r);
            OFF_ID:    mmio_rd_s = DATA_W'(ID_VALUE);
            default:   mmio_rd_s = {DATA_W{1'b0}};
        endcase
    end

    // MMIO state and read-path select registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_r       <= {LED_W{1'b0}};
            cycle_cnt_r <= 32'd0;
            wr_cnt_r    <= 32'd0;
            mmio_q_r    <= {DATA_W{1'b0}};
            mmio_hit_r  <= 1'b0;
            ram_sel_r   <= 1'b0;
        end else begin
            led_r       <= led_nxt_s;
            cycle_cnt_r <= cycle_nxt_s;
            wr_cnt_r    <= wr_cnt_nxt_s;
            mmio_q_r    <= mmio_rd_s;
            mmio_hit_r  <= is_mmio_s;
            ram_sel_r   <= ~is_mmio_s;
        end
    end

    // ram_sel_r is cleared by reset, so q reads as zero until the first real access.
    assign q        = ram_sel_r ? ram_q_s : mmio_q_r;
    assign led_out  = led_r;
    assign mmio_hit = mmio_hit_r;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory port: `address`, `data`, `wren` in; `q` out.
- Drop-in, behaviourally exact replacement for the generated dmem syncram, plus a small memory-mapped I/O window at the top of the address space.
- Used in simulation and on the board so programs can drive LEDs and read cycle/write counters through ordinary lw/sw.
- Top level feeds it the inverted processor clock, as for dmem today.

Parameters:
- ADDR_W, 12, word-address width.
- DATA_W, 32, data width.
- MMIO_BASE, 12'hFF0, first address of the 16-word MMIO window; RAM is addresses 0 .. MMIO_BASE-1.
- LED_W, 8, width of the LED output register.

Ports:
- clock  in  1  sampling clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address from processor.
- data  in  DATA_W  write data.
- wren  in  1  write enable, sampled with address/data.
- q  out  DATA_W  registered read data.
- led_out  out  LED_W  LED register contents.
- mmio_hit  out  1  registered flag: the access that produced the current q targeted the MMIO window.

Behaviour:
- Reset (reset==0, async): q=0, mmio_hit=0, led_out=0, cycle_cnt=0, wr_cnt=0. RAM contents are not cleared. An access sampled on an edge while reset==0 is ignored entirely, including any RAM write.
- Read latency is 1 cycle. At edge N, address is sampled; after edge N, q holds the value at that address as it was before edge N.
- Read-during-write, same address, same edge: q returns the old data. This matches the syncram "old data" setting.
- Reads happen every cycle regardless of wren; there is no read enable.
- RAM writes: when wren=1 and address < MMIO_BASE, RAM[address] <= data at the edge.
- MMIO decode: address >= MMIO_BASE. Offset = address - MMIO_BASE (4 bits).
  - Offset 0, LED: read/write. A write loads data[LED_W-1:0]. A read returns the LED value zero-extended.
  - Offset 1, CYCLE: cycle_cnt, 32-bit, increments every non-reset edge and wraps 0xFFFFFFFF->0. A read returns the pre-edge value. A write loads data; that edge does not also increment.
  - Offset 2, WRCNT: wr_cnt, counts RAM writes only (not MMIO writes). Saturates at 0xFFFFFFFF. A write clears it to 0 regardless of data.
  - Offset 3, ID: read-only constant 32'h0550_D3E0; writes ignored.
  - Offsets 4..15: read 0; writes ignored.
- MMIO writes never modify RAM. RAM addresses never touch MMIO state.
- mmio_hit <= (address >= MMIO_BASE) every edge, so it aligns with q.
- Boundary: address MMIO_BASE-1 is RAM; MMIO_BASE is LED.
- Width rules: no sign extension anywhere. Unused upper LED read bits are 0.
- No handshake: the processor assumes fixed 1-cycle latency, so the block never stalls.
- No X on q after reset, except a read of never-written RAM.

Decomposition:
- Shared package `dmem_pkg`:
  - MMIO offset constants: OFF_LED=0, OFF_CYCLE=1, OFF_WRCNT=2, OFF_ID=3.
  - ID_VALUE constant.
  - Default MMIO_BASE.
- One sub-module: `dmem_ram_1rw`, single-port synchronous RAM with old-data read-during-write and no reset. Inferred array, so it maps to block RAM.
- Decode, registers, counters and output mux live in `dmem_responder`.

Test Plan:
- Reset then idle 5 edges, read 0xFF1 -> q=5 one cycle later (pre-edge value). led_out=0, mmio_hit=1.
- Write 0x0000_1234 to 0x010, then read 0x010 next edge -> q=0x1234 after the read edge. WRCNT read -> 1.
- Same-edge write 0xAAAA_AAAA to 0x020 (previously 0x5555_5555) -> q=0x5555_5555. The following read returns 0xAAAA_AAAA.
- sw 0x0000_01A5 to 0xFF0 -> led_out=0xA5 after the edge; RAM[0xFEF] unchanged; WRCNT unchanged; read 0xFF0 -> 0x000000A5. Read 0xFF3 -> 0x0550_D3E0; read 0xFF9 -> 0.
- Write 0xFFFF_FFFE to 0xFF1, idle 2 edges, read -> q=0x0000_0000 (wrap).
- Preload WRCNT by forcing it to 0xFFFFFFFF, RAM write -> stays 0xFFFFFFFF.
- Assert reset mid-write with wren=1 at the edge -> RAM unchanged; all outputs 0 immediately (async, no edge needed).
